// File: rtl/inv_key_expansion.sv
// Reverse-order AES-128 round-key generator: starts from the round-10 key and
// walks the key schedule backwards one 32-bit word per cycle, presenting keys 10..0.

module aes_sbox (
  input  logic [7:0] a,
  output logic [7:0] y
);
  // Forward AES S-box, entry 0x00 in the most significant byte.
  localparam logic [2047:0] SBOX = {
    128'h637c777bf26b6fc53001672bfed7ab76,
    128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115,
    128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84,
    128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8,
    128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973,
    128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479,
    128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
    128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df,
    128'h8ca1890dbfe6426841992d0fb054bb16
  };

  // Entry a sits at bit offset (255-a)*8, and 255-a == ~a for an 8-bit index.
  assign y = SBOX[{~a, 3'b000} +: 8];
endmodule

module inv_key_expansion #(
  parameter int unsigned NUM_ROUNDS = 10
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic [127:0] last_key,
  input  logic         key_ready,
  output logic [127:0] round_key,
  output logic         key_valid,
  output logic [3:0]   key_round,
  output logic         busy,
  output logic         done
);
  typedef enum logic [1:0] {
    IDLE,
    PRESENT,
    COMPUTE
  } state_t;

  state_t       state_q, state_d;
  logic [127:0] key_q, key_d;
  logic [3:0]   round_q, round_d;
  logic [1:0]   idx_q, idx_d;
  logic         done_q, done_d;

  logic [31:0] w0, w1, w2, w3;
  logic [31:0] rot, sub;
  logic [7:0]  rcon;

  assign w0 = key_q[127:96];
  assign w1 = key_q[95:64];
  assign w2 = key_q[63:32];
  assign w3 = key_q[31:0];

  // w3 has already been rewritten by the idx3 step when idx0 consumes it.
  assign rot = {w3[23:0], w3[31:24]};

  aes_sbox u_sbox0 (.a(rot[31:24]), .y(sub[31:24]));
  aes_sbox u_sbox1 (.a(rot[23:16]), .y(sub[23:16]));
  aes_sbox u_sbox2 (.a(rot[15:8]),  .y(sub[15:8]));
  aes_sbox u_sbox3 (.a(rot[7:0]),   .y(sub[7:0]));

  // Step r -> r-1 uses Rcon table entry r-1.
  always_comb begin
    rcon = 8'h00;
    case (round_q)
      4'd1:    rcon = 8'h01;
      4'd2:    rcon = 8'h02;
      4'd3:    rcon = 8'h04;
      4'd4:    rcon = 8'h08;
      4'd5:    rcon = 8'h10;
      4'd6:    rcon = 8'h20;
      4'd7:    rcon = 8'h40;
      4'd8:    rcon = 8'h80;
      4'd9:    rcon = 8'h1b;
      4'd10:   rcon = 8'h36;
      default: rcon = 8'h00;
    endcase
  end

  always_comb begin
    state_d = state_q;
    key_d   = key_q;
    round_d = round_q;
    idx_d   = idx_q;
    done_d  = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) begin
          key_d   = last_key;
          round_d = 4'(NUM_ROUNDS);
          state_d = PRESENT;
        end
      end
      PRESENT: begin
        if (key_ready) begin
          if (round_q == 4'd0) begin
            state_d = IDLE;
            done_d  = 1'b1;
          end else begin
            idx_d   = 2'd3;
            state_d = COMPUTE;
          end
        end
      end
      COMPUTE: begin
        idx_d = idx_q - 2'd1;
        case (idx_q)
          2'd3: key_d[31:0]   = w3 ^ w2;
          2'd2: key_d[63:32]  = w2 ^ w1;
          2'd1: key_d[95:64]  = w1 ^ w0;
          default: begin
            key_d[127:96] = w0 ^ sub ^ {rcon, 24'h000000};
            round_d       = round_q - 4'd1;
            state_d       = PRESENT;
          end
        endcase
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      key_q   <= '0;
      round_q <= '0;
      idx_q   <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      key_q   <= key_d;
      round_q <= round_d;
      idx_q   <= idx_d;
      done_q  <= done_d;
    end
  end

  assign round_key = key_q;
  assign key_round = round_q;
  assign key_valid = (state_q == PRESENT);
  assign busy      = (state_q != IDLE);
  assign done      = done_q;
endmodule

// File: tb/tb_inv_key_expansion.sv
// Scoreboard bench for inv_key_expansion: stimulus queues expected (round, key)
// pairs; a negedge monitor checks every presented key against the queue head.

module tb_inv_key_expansion;
  logic         clk = 1'b0;
  logic         rst;
  logic         start;
  logic [127:0] last_key;
  logic         key_ready;
  logic [127:0] round_key;
  logic         key_valid;
  logic [3:0]   key_round;
  logic         busy;
  logic         done;

  always #5 clk = ~clk;

  inv_key_expansion #(.NUM_ROUNDS(10)) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .last_key  (last_key),
    .key_ready (key_ready),
    .round_key (round_key),
    .key_valid (key_valid),
    .key_round (key_round),
    .busy      (busy),
    .done      (done)
  );

  typedef struct packed {
    logic [3:0]   rnd;
    logic [127:0] key;
  } exp_t;

  exp_t         exp_q[$];
  int           checks = 0;
  int           errors = 0;
  logic [7:0]   sbox_m [256];
  logic [127:0] gold [11];
  logic [127:0] model_rk [11];

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h, required %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Expected keys are consumed by the monitor; a held key is re-checked each cycle.
  always @(negedge clk) begin
    if (!rst && key_valid) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_key: got round %0d key %h, required no key", key_round, round_key);
      end else begin
        check("key_round", 128'(key_round), 128'(exp_q[0].rnd));
        check("round_key", round_key, exp_q[0].key);
        if (key_ready) void'(exp_q.pop_front());
      end
    end
  end

  function automatic logic [7:0] gmul(input logic [7:0] a_in, input logic [7:0] b_in);
    logic [7:0] a = a_in;
    logic [7:0] b = b_in;
    logic [7:0] p = 8'h00;
    for (int i = 0; i < 8; i++) begin
      if (b[0]) p = p ^ a;
      a = {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
      b = {1'b0, b[7:1]};
    end
    return p;
  endfunction

  function automatic logic [7:0] rotl1(input logic [7:0] b);
    return {b[6:0], b[7]};
  endfunction

  task automatic build_sbox();
    for (int x = 0; x < 256; x++) begin
      logic [7:0] inv = 8'h00;
      logic [7:0] s;
      for (int y = 1; y < 256; y++)
        if (gmul(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
      s = inv ^ rotl1(inv) ^ rotl1(rotl1(inv)) ^ rotl1(rotl1(rotl1(inv)))
          ^ rotl1(rotl1(rotl1(rotl1(inv)))) ^ 8'h63;
      sbox_m[x] = s;
    end
  endtask

  function automatic logic [31:0] subw(input logic [31:0] w);
    return {sbox_m[w[31:24]], sbox_m[w[23:16]], sbox_m[w[15:8]], sbox_m[w[7:0]]};
  endfunction

  // Forward FIPS-197 expansion from the cipher key into model_rk[0..10].
  task automatic expand(input logic [127:0] k0);
    logic [31:0] w [44];
    logic [31:0] t;
    logic [7:0]  rc = 8'h01;
    for (int i = 0; i < 4; i++) w[i] = k0[127 - 32*i -: 32];
    for (int i = 4; i < 44; i++) begin
      t = w[i-1];
      if (i % 4 == 0) begin
        t  = subw({t[23:0], t[31:24]}) ^ {rc, 24'h000000};
        rc = {rc[6:0], 1'b0} ^ (rc[7] ? 8'h1b : 8'h00);
      end
      w[i] = w[i-4] ^ t;
    end
    for (int r = 0; r < 11; r++) model_rk[r] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
  endtask

  task automatic push_keys(input bit use_gold);
    for (int r = 10; r >= 0; r--)
      exp_q.push_back('{rnd: 4'(r), key: (use_gold ? gold[r] : model_rk[r])});
  endtask

  task automatic check_zero(input string tag);
    check({tag, "_round_key"}, round_key, 128'h0);
    check({tag, "_key_valid"}, 128'(key_valid), 128'h0);
    check({tag, "_key_round"}, 128'(key_round), 128'h0);
    check({tag, "_busy"}, 128'(busy), 128'h0);
    check({tag, "_done"}, 128'(done), 128'h0);
  endtask

  task automatic issue_start(input logic [127:0] k);
    last_key = k;
    start    = 1'b1;
    tick();
    start    = 1'b0;
  endtask

  task automatic wait_done(input bit rand_ready, input int budget);
    int n = 0;
    while (!done && n < budget) begin
      key_ready = rand_ready ? ($urandom_range(0, 3) != 0) : 1'b1;
      tick();
      n++;
    end
    if (!done) begin
      errors++;
      $display("FAIL done_timeout: got no done within %0d cycles, required done pulse", budget);
    end
    key_ready = 1'b1;
  endtask

  task automatic run_gold_timed();
    push_keys(1'b1);
    key_ready = 1'b1;
    issue_start(gold[10]);
    for (int c = 1; c <= 52; c++) begin
      check("valid_timing", 128'(key_valid), 128'((c <= 51) && ((c - 1) % 5 == 0)));
      check("done_timing", 128'(done), 128'(c == 52));
      check("busy_timing", 128'(busy), 128'(c < 52));
      if (c < 52) tick();
    end
    check("queue_drained", 128'(exp_q.size()), 128'h0);
  endtask

  initial begin
    gold[0]  = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    gold[1]  = 128'ha0fafe1788542cb123a339392a6c7605;
    gold[2]  = 128'hf2c295f27a96b9435935807a7359f67f;
    gold[3]  = 128'h3d80477d4716fe3e1e237e446d7a883b;
    gold[4]  = 128'hef44a541a8525b7fb671253bdb0bad00;
    gold[5]  = 128'hd4d1c6f87c839d87caf2b8bc11f915bc;
    gold[6]  = 128'h6d88a37a110b3efddbf98641ca0093fd;
    gold[7]  = 128'h4e54f70e5f5fc9f384a64fb24ea6dc4f;
    gold[8]  = 128'head27321b58dbad2312bf5607f8d292f;
    gold[9]  = 128'hac7766f319fadc2128d12941575c006e;
    gold[10] = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;

    rst = 1'b1; start = 1'b0; key_ready = 1'b0; last_key = '0;
    build_sbox();

    for (int i = 0; i < 3; i++) begin
      tick();
      check_zero("reset");
    end
    rst = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      check_zero("idle");
    end

    // Model cross-check against the FIPS-197 table.
    expand(gold[0]);
    check("model_round10", model_rk[10], gold[10]);

    run_gold_timed();

    // Back-pressure during round 9.
    begin
      int n = 0;
      push_keys(1'b1);
      key_ready = 1'b1;
      issue_start(gold[10]);
      while (!(key_valid && key_round == 4'd9) && n < 20) begin tick(); n++; end
      check("reach_round9", 128'(key_round), 128'd9);
      key_ready = 1'b0;
      repeat (7) tick();
      key_ready = 1'b1;
      n = 0;
      do begin tick(); n++; end while (!key_valid && n < 20);
      check("resume_latency", 128'(n), 128'd5);
      check("resume_round", 128'(key_round), 128'd8);
      wait_done(1'b0, 100);
      check("bp_drained", 128'(exp_q.size()), 128'h0);
    end

    // Start while busy is ignored.
    push_keys(1'b1);
    issue_start(gold[10]);
    repeat (19) tick();
    last_key = 128'h0123456789abcdeffedcba9876543210;
    start    = 1'b1;
    tick();
    start    = 1'b0;
    check("busy_at_restart", 128'(busy), 128'h1);
    wait_done(1'b0, 100);
    check("busy_start_drained", 128'(exp_q.size()), 128'h0);
    tick();

    // Reset mid-sequence, then a clean run.
    push_keys(1'b1);
    issue_start(gold[10]);
    repeat (21) tick();
    rst = 1'b1;
    exp_q.delete();
    tick();
    check_zero("midreset");
    rst = 1'b0;
    tick();
    check_zero("post_reset");
    run_gold_timed();

    // Random schedules; each start lands in the previous done cycle.
    for (int k = 0; k < 50; k++) begin
      expand({$urandom, $urandom, $urandom, $urandom});
      push_keys(1'b0);
      issue_start(model_rk[10]);
      wait_done(1'b1, 600);
      check("rand_drained", 128'(exp_q.size()), 128'h0);
    end

    key_ready = 1'b1;
    repeat (3) tick();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
